// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative integer multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes at start, iterated one bit per cycle in
// CALC (shift-add multiply or restoring divide), then sign-corrected in FIX.
module ex_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Start,
   input  logic [2:0]      Op,
   input  logic [XLEN-1:0] OpA,
   input  logic [XLEN-1:0] OpB,
   input  logic            Flush,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Hi,
   output logic [XLEN-1:0] Lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam logic [2:0] OP_MULT = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd2;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [XLEN-1:0]     r_acc;      // running high product / partial remainder
   logic [XLEN-1:0]     r_mq;       // multiplier / dividend, becomes low product / quotient
   logic [XLEN-1:0]     r_b;        // multiplicand / divisor magnitude
   logic [XLEN-1:0]     r_a;        // original dividend, returned as HI on divide by zero
   logic                r_is_div, r_neg_q, r_neg_r, r_div0;
   logic                r_busy, r_done;
   logic [XLEN-1:0]     r_hi, r_lo;

   logic                w_signed, w_a_neg, w_b_neg, w_start, w_last;
   logic [XLEN-1:0]     w_a_mag, w_b_mag;
   logic [XLEN:0]       w_sum, w_rem_sh, w_diff;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_fix_hi, w_fix_lo;

   // Operand decode: signed ops work on magnitudes and remember the signs.
   assign w_signed = (Op == OP_MULT) || (Op == OP_DIV);
   assign w_a_neg  = w_signed & OpA[XLEN-1];
   assign w_b_neg  = w_signed & OpB[XLEN-1];
   assign w_a_mag  = w_a_neg ? -OpA : OpA;
   assign w_b_mag  = w_b_neg ? -OpB : OpB;
   assign w_start  = (r_state == S_IDLE) && Start && !Op[2] && !Flush;
   assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

   // One iteration step: add-and-shift for multiply, trial subtract for divide.
   assign w_sum    = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
   assign w_rem_sh = {r_acc, r_mq[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_b};

   // FIX-stage sign correction and special cases.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_prod   = {r_acc, r_mq};
      w_fix_hi = '0;
      w_fix_lo = '0;
      if (r_neg_q) w_prod = -{r_acc, r_mq};
      if (!r_is_div) begin
         w_fix_hi = w_prod[2*XLEN-1:XLEN];
         w_fix_lo = w_prod[XLEN-1:0];
      end else if (r_div0) begin
         w_fix_hi = r_a;
         w_fix_lo = '1;
      end else begin
         w_fix_hi = r_neg_r ? -r_acc : r_acc;
         w_fix_lo = r_neg_q ? -r_mq : r_mq;
      end
   end

   // Next-state logic: flush always returns to IDLE, CALC runs XLEN cycles.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_CALC;
         S_CALC:  if (Flush) w_next = S_IDLE;
                  else if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State, Busy and Done registers.
   always_ff @(posedge CLK or negedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!RST) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (r_state == S_FIX) && !Flush;
      end
   end

   // Iteration datapath: latch magnitudes at start, then one bit per CALC cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_b      <= '0;
         r_a      <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
      end else if (w_start) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mq     <= w_a_mag;
         r_b      <= w_b_mag;
         r_a      <= OpA;
         r_is_div <= Op[1];
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_div0   <= (OpB == '0);
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (!r_is_div) begin
            r_acc <= w_sum[XLEN:1];
            r_mq  <= {w_sum[0], r_mq[XLEN-1:1]};
         end else if (!w_diff[XLEN]) begin
            r_acc <= w_diff[XLEN-1:0];
            r_mq  <= {r_mq[XLEN-2:0], 1'b1};
         end else begin
            r_acc <= w_rem_sh[XLEN-1:0];
            r_mq  <= {r_mq[XLEN-2:0], 1'b0};
         end
      end
   end

   // HI/LO: written only by FIX completion or an accepted MTHI/MTLO.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == S_FIX && !Flush) begin
         r_hi <= w_fix_hi;
         r_lo <= w_fix_lo;
      end else if (r_state == S_IDLE && Start && !Flush) begin
         if (Op == OP_MTHI) r_hi <= OpA;
         if (Op == OP_MTLO) r_lo <= OpA;
      end
   end

   assign Busy = r_busy;
   assign Done = r_done;
   assign Hi   = r_hi;
   assign Lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv at XLEN=32 with hand-computed results.
module tb_ex_muldiv;

   logic        CLK, RST, Start, Flush, Busy, Done;
   logic [2:0]  Op;
   logic [31:0] OpA, OpB, Hi, Lo;
   int          n_cmp = 0;
   int          n_bad = 0;

   ex_muldiv #(.XLEN(32)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
      .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issue one MULT/DIV operation and check latency, Busy length, result, Done pulse.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int edges, busy_cnt;
      Start = 1'b1; Op = op; OpA = a; OpB = b;
      tick();
      Start = 1'b0;
      edges = 1;
      busy_cnt = 0;
      while (!Done && edges < 100) begin
         if (Busy) busy_cnt++;
         tick();
         edges++;
      end
      check({tag, " latency"}, edges, 34);
      check({tag, " busy_cycles"}, busy_cnt, 33);
      check({tag, " hi"}, Hi, exp_hi);
      check({tag, " lo"}, Lo, exp_lo);
      check({tag, " busy_at_done"}, Busy, 0);
      tick();
      check({tag, " done_pulse"}, Done, 0);
   endtask

   initial begin
      int dones;
      Start = 0; Flush = 0; Op = 0; OpA = 0; OpB = 0;
      RST = 1'b1;
      #1 RST = 1'b0;
      tick(); tick();
      check("reset busy", Busy, 0);
      check("reset done", Done, 0);
      check("reset hi", Hi, 0);
      check("reset lo", Lo, 0);
      RST = 1'b1;

      run_op("mult -3*7",   3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("multu max",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult min*min",3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_op("mult -1*1",   3'd0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("div -7/2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div 7/-2",    3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu 7/0",    3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
      run_op("div -5/0",    3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("div ovf",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("divu 100/7",  3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);

      // Flush at CALC cycle 10 of a DIVU; an MTLO issued while busy must be ignored.
      Start = 1'b1; Op = 3'd3; OpA = 32'd1000; OpB = 32'd3;
      tick();
      Start = 1'b0;
      for (int i = 2; i <= 10; i++) begin
         if (i == 3) begin
            Start = 1'b1; Op = 3'd5; OpA = 32'h00000BAD;
         end else begin
            Start = 1'b0;
         end
         tick();
      end
      Start = 1'b0;
      check("flush pre busy", Busy, 1);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("flush busy", Busy, 0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done) dones++;
         tick();
      end
      check("flush no done", dones, 0);
      check("flush hi kept", Hi, 32'h00000002);
      check("flush lo kept", Lo, 32'h0000000E);

      // Back-to-back MTHI then MTLO.
      Start = 1'b1; Op = 3'd4; OpA = 32'h12345678;
      tick();
      check("mthi hi", Hi, 32'h12345678);
      check("mthi lo kept", Lo, 32'h0000000E);
      check("mthi busy", Busy, 0);
      Op = 3'd5; OpA = 32'hCAFEF00D;
      tick();
      Start = 1'b0;
      check("mtlo lo", Lo, 32'hCAFEF00D);
      check("mtlo hi kept", Hi, 32'h12345678);
      check("mtlo busy", Busy, 0);
      check("mtlo done", Done, 0);

      // Op 6 is a no-op.
      Start = 1'b1; Op = 3'd6; OpA = 32'h55555555;
      tick();
      Start = 1'b0;
      check("nop busy", Busy, 0);
      check("nop hi", Hi, 32'h12345678);
      check("nop lo", Lo, 32'hCAFEF00D);

      // Flush wins over Start in IDLE, for both a MULTU and an MTHI.
      Start = 1'b1; Flush = 1'b1; Op = 3'd1; OpA = 32'd5; OpB = 32'd5;
      tick();
      check("flush+start busy", Busy, 0);
      Op = 3'd4; OpA = 32'h0BADBEEF;
      tick();
      Start = 1'b0; Flush = 1'b0;
      check("flush+mthi hi", Hi, 32'h12345678);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done) dones++;
         tick();
      end
      check("flush+start no done", dones, 0);

      // Asynchronous reset in the middle of a MULT.
      Start = 1'b1; Op = 3'd0; OpA = 32'd9; OpB = 32'd9;
      for (int i = 0; i < 5; i++) begin
         tick();
         Start = 1'b0;
      end
      check("mid busy", Busy, 1);
      #2 RST = 1'b0;
      #1;
      check("async busy", Busy, 0);
      check("async hi", Hi, 0);
      check("async lo", Lo, 0);
      check("async done", Done, 0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (Done) dones++;
      end
      check("held reset no done", dones, 0);

      // First edge after reset release accepts a Start.
      RST = 1'b1;
      run_op("post-reset multu", 3'd1, 32'd6, 32'd7, 32'h00000000, 32'h0000002A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand width; legal values 8..64, even only.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1: iteration counter width.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous assert, active-low; reset is asserted while RST=0.
REQ-005 Start  input  1  request; sampled only in IDLE.
REQ-006 Op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
REQ-007 OpA  input  XLEN  rs operand (multiplicand / dividend / MTHI-MTLO source).
REQ-008 OpB  input  XLEN  rt operand (multiplier / divisor).
REQ-009 Flush  input  1  synchronous abort of the in-flight operation.
REQ-010 Busy  output  1  registered; high while an operation occupies the unit.
REQ-011 Done  output  1  registered one-cycle pulse; Hi/Lo hold the new result in that cycle.
REQ-012 Hi  output  XLEN  HI register (high product / remainder).
REQ-013 Lo  output  XLEN  LO register (low product / quotient).

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX; reset state IDLE.
REQ-015 In IDLE, Start=1 with Op 0-3 at edge k SHALL latch operands, clear the counter and enter CALC; Busy=1 from edge k.
REQ-016 CALC SHALL run exactly XLEN cycles, one bit per cycle (shift-add multiply; restoring divide), then enter FIX.
REQ-017 FIX SHALL last one cycle, apply sign correction, write Hi/Lo and return to IDLE; Done=1 and Busy=0 after that edge.
REQ-018 Start-to-Done latency SHALL be XLEN+2 edges; Busy SHALL be high for exactly XLEN+1 cycles.
REQ-019 Done SHALL be high for exactly one cycle; a new Start is accepted in the cycle Done is high.
REQ-020 Start while Busy=1 SHALL be ignored; no queuing.
REQ-021 MTHI/MTLO in IDLE SHALL write OpA to Hi/Lo at the next edge; Busy and Done stay 0.
REQ-022 Op 6/7 SHALL have no effect.
REQ-023 MULT/DIV SHALL treat operands as two's complement; MULTU/DIVU as unsigned.
REQ-024 Multiply SHALL yield the full 2*XLEN product: {Hi,Lo} = OpA*OpB.
REQ-025 Signed divide SHALL truncate the quotient toward zero; remainder takes the dividend's sign; unsigned per the usual definition.
REQ-026 Divide by zero (OpB=0) SHALL complete at normal latency with Lo = all ones, Hi = OpA.
REQ-027 Signed overflow (OpA = most-negative, OpB = -1) SHALL give Lo = OpA, Hi = 0.
REQ-028 Flush=1 in CALC or FIX SHALL return to IDLE at the next edge; Busy=0, no Done, Hi/Lo unchanged.
REQ-029 Flush and Start in the same IDLE cycle: Flush SHALL win; the request is dropped.
REQ-030 Hi/Lo SHALL change only on FIX completion or MTHI/MTLO; they hold otherwise.

Reset
REQ-031 RST=0 SHALL immediately force IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0, independent of CLK.
REQ-032 Reset mid-operation SHALL discard the operation; no Done after RST deasserts.
REQ-033 After RST returns to 1, the first rising edge SHALL accept a Start.

Verification (XLEN=32)
REQ-034 MULT OpA=0xFFFFFFFD (-3), OpB=7 -> Done at edge 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high 33 cycles.
REQ-035 MULTU OpA=OpB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-036 DIV OpA=-7 (0xFFFFFFF9), OpB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU 7/0 -> Lo=0xFFFFFFFF, Hi=7.
REQ-037 DIV OpA=0x80000000, OpB=0xFFFFFFFF -> Lo=0x80000000, Hi=0; no hang, normal latency.
REQ-038 Start DIVU, Flush at CALC cycle 10 -> Busy=0 next cycle, no Done, Hi/Lo keep prior values; Start during Busy ignored.
REQ-039 MTHI 0x12345678, then MTLO 0xCAFEF00D on consecutive cycles -> Hi/Lo updated at each next edge, no Busy/Done; RST=0 mid-MULT clears all outputs asynchronously.
